// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Shares one single-port T SRAM between the data processor's
//             T read-back (prefetch) stream, its buffered T write-back stream
//             and host preload. Reads win over buffered writes. Both streams
//             use circular word pointers that wrap at the per-pass word count.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n         clock, asynchronous active-low reset
//    i_start / i_stop   sequencing pulses (IDLE->RUN, RUN->FLUSH)
//    i_word_num         words per T pass (wrap point, 0 behaves as 1)
//    i_rd_req           level read request; o_rd_data returns 2 cycles later
//                       with MSB forced to 1, otherwise all-zero
//    i_wr_req/i_wr_data write-back push into the write buffer
//    i_host_*           host preload write, honoured only in IDLE
//    o_host_ready       high in IDLE
//    o_sram_*           SRAM macro interface (combinational)
//    i_sram_rdata       SRAM read data, one cycle after a read access
//    o_busy             state != IDLE
//    o_overflow         sticky: write dropped on a full buffer
//  Configuration
//    SRAM_ARB_STATS_EN  adds o_wr_wait_cnt: saturating count of RUN/FLUSH
//                       cycles with buffered data but no write grant
// ============================================================================
module sram_port_arbiter #(
  parameter int WORD_W     = 64,
  parameter int ADDR_W     = 10,
  parameter int WBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_word_num,
  input  logic              i_rd_req,
  output logic [WORD_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [WORD_W-1:0] i_host_wdata,
  output logic              o_host_ready,
  output logic              o_sram_en,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [WORD_W-1:0] o_sram_wdata,
  input  logic [WORD_W-1:0] i_sram_rdata,
  output logic              o_busy,
  output logic              o_overflow
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       o_wr_wait_cnt
`endif
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WORD_W-1:0] VALID_FLAG = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  last_word;
  logic [1:0]         rd_pipe;     // [0]: read issued last cycle, [1]: two cycles ago
  logic [WORD_W-1:0]  buf_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]   buf_head;
  logic [PTR_W-1:0]   buf_tail;
  logic [CNT_W-1:0]   buf_count;

  logic rd_lockout;
  logic rd_grant;
  logic wr_grant;
  logic buf_empty;
  logic buf_full;
  logic push_req;
  logic push;
  logic drop;
  logic host_wr;

  // Word count 0 behaves as a one-word pass.
  assign last_word = (i_word_num == '0) ? '0 : i_word_num - ADDR_W'(1);

  // '>=' rather than '==' so a pointer left beyond a shrunken pass still wraps.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr,
                                                input logic [ADDR_W-1:0] last);
    return (ptr >= last) ? '0 : ptr + ADDR_W'(1);
  endfunction

  assign rd_lockout = |rd_pipe;
  assign buf_empty  = (buf_count == '0);
  assign buf_full   = (buf_count == CNT_W'(WBUF_DEPTH));
  assign rd_grant   = (state == ST_RUN) && i_rd_req && !rd_lockout;
  assign wr_grant   = (state != ST_IDLE) && !rd_grant && !buf_empty;
  assign push_req   = (state != ST_IDLE) && i_wr_req;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push       = push_req && (!buf_full || wr_grant);
  assign drop       = push_req && buf_full && !wr_grant;
  assign host_wr    = (state == ST_IDLE) && i_host_we;

  always_comb begin
    o_sram_en    = 1'b0;
    o_sram_we    = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (host_wr) begin
      o_sram_en    = 1'b1;
      o_sram_we    = 1'b1;
      o_sram_addr  = i_host_addr;
      o_sram_wdata = i_host_wdata;
    end else if (rd_grant) begin
      o_sram_en    = 1'b1;
      o_sram_addr  = rd_ptr;
    end else if (wr_grant) begin
      o_sram_en    = 1'b1;
      o_sram_we    = 1'b1;
      o_sram_addr  = wr_ptr;
      o_sram_wdata = buf_mem[buf_head];
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by buf_count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[buf_tail] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      o_busy       <= 1'b0;
      o_host_ready <= 1'b1;
      o_overflow   <= 1'b0;
      o_rd_data    <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      rd_pipe      <= '0;
      buf_head     <= '0;
      buf_tail     <= '0;
      buf_count    <= '0;
    end else begin
      rd_pipe   <= {rd_pipe[0], rd_grant};
      o_rd_data <= rd_pipe[0] ? (i_sram_rdata | VALID_FLAG) : '0;
      if (rd_grant) begin
        rd_ptr <= ptr_inc(rd_ptr, last_word);
      end
      if (wr_grant) begin
        wr_ptr   <= ptr_inc(wr_ptr, last_word);
        buf_head <= buf_head + PTR_W'(1);
      end
      if (push) begin
        buf_tail <= buf_tail + PTR_W'(1);
      end
      buf_count <= buf_count + CNT_W'(push) - CNT_W'(wr_grant);
      if (drop) begin
        o_overflow <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state        <= ST_RUN;
            o_busy       <= 1'b1;
            o_host_ready <= 1'b0;
            o_overflow   <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            buf_head     <= '0;
            buf_tail     <= '0;
            buf_count    <= '0;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Leave only once nothing is buffered, nothing arrives this cycle
          // and no read data is still to be captured.
          if (buf_empty && !push_req && !rd_pipe[0]) begin
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
            o_host_ready <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          o_busy       <= 1'b0;
          o_host_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wr_wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (i_start) begin
        o_wr_wait_cnt <= '0;
      end
    end else if (!buf_empty && !wr_grant && (o_wr_wait_cnt != 16'hFFFF)) begin
      o_wr_wait_cnt <= o_wr_wait_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
